// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FSM encodings and sizing helper for the handshake FIFO
package fifo_pkg;

    typedef enum logic {
        T_IDLE,
        T_ACK
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PRES,
        R_ACK
    } rx_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - WIDTH x DEPTH storage, one write port, one registered read port
module fifo_mem #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int ADR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately left without reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/param_hs_fifo.sv
// rtl/param_hs_fifo.sv - FIFO with req/ack handshakes on both sides and registered status
module param_hs_fifo
    import fifo_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  DEPTH     = 8,
    parameter int  AF_LEVEL  = DEPTH - 1,
    parameter int  AE_LEVEL  = 1,
    localparam int ADR_WIDTH = clog2(DEPTH),
    localparam int CNT_WIDTH = clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_rdy,
    output logic                 tx_done,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 rx_rdy,
    input  logic                 rx_done,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] level,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 almost_empty
);

    tx_state_e            tx_state_q, tx_state_d;
    rx_state_e            rx_state_q, rx_state_d;
    logic [ADR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] level_q, level_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 af_q, af_d;
    logic                 ae_q, ae_d;
    logic                 push, pop, rd_en;
    logic [WIDTH-1:0]     rd_data;

    function automatic logic [ADR_WIDTH-1:0] ptr_inc(input logic [ADR_WIDTH-1:0] p);
        return (p == ADR_WIDTH'(DEPTH - 1)) ? '0 : p + ADR_WIDTH'(1);
    endfunction

    always_comb begin
        tx_state_d = tx_state_q;
        rx_state_d = rx_state_q;
        push       = 1'b0;
        pop        = 1'b0;
        rd_en      = 1'b0;

        case (tx_state_q)
            T_IDLE:  if (tx_rdy && !full_q) begin
                         push       = 1'b1;
                         tx_state_d = T_ACK;
                     end
            T_ACK:   if (!tx_rdy) tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase

        // The read port is registered, so the load in R_IDLE lands exactly as R_PRES begins.
        case (rx_state_q)
            R_IDLE:  if (!empty_q) begin
                         rd_en      = 1'b1;
                         rx_state_d = R_PRES;
                     end
            R_PRES:  if (rx_done) begin
                         pop        = 1'b1;
                         rx_state_d = R_ACK;
                     end
            R_ACK:   if (!rx_done) rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase

        if (flush) begin
            tx_state_d = T_IDLE;
            rx_state_d = R_IDLE;
            push       = 1'b0;
            pop        = 1'b0;
            rd_en      = 1'b0;
        end

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + CNT_WIDTH'(1);
        end else if (pop && !push) begin
            level_d = level_q - CNT_WIDTH'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        // Flags derive from the next level so they stay coherent with level every cycle.
        empty_d = (level_d == '0);
        full_d  = (level_d == CNT_WIDTH'(DEPTH));
        af_d    = (int'(level_d) >= AF_LEVEL);
        ae_d    = (int'(level_d) <= AE_LEVEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= T_IDLE;
            rx_state_q <= R_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= (AF_LEVEL == 0);
            ae_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
        end
    end

    fifo_mem #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADR_WIDTH (ADR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // Handshake outputs are state-decoded, so reset and flush clear them with the FSMs.
    assign tx_done      = (tx_state_q == T_ACK);
    assign rx_rdy       = (rx_state_q == R_PRES);
    assign out_data     = rx_rdy ? rd_data : '0;
    assign level        = level_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule

// File: tb/tb_param_hs_fifo.sv
// tb/tb_param_hs_fifo.sv - directed self-checking bench for param_hs_fifo
module tb_param_hs_fifo;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_tx_rdy, a_tx_done, a_rx_rdy, a_rx_done, a_flush;
    logic [7:0] a_in_data, a_out_data;
    logic [2:0] a_level;
    logic       a_empty, a_full, a_af, a_ae;

    logic       b_tx_rdy, b_tx_done, b_rx_rdy, b_rx_done, b_flush;
    logic [7:0] b_in_data, b_out_data;
    logic [2:0] b_level;
    logic       b_empty, b_full, b_af, b_ae;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fill_v [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] order_v [7] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07};
    logic       b_af_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       b_ae_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    param_hs_fifo #(.WIDTH(8), .DEPTH(5)) dut_a (
        .clk (clk), .rst_n (rst_n),
        .tx_rdy (a_tx_rdy), .tx_done (a_tx_done), .in_data (a_in_data),
        .rx_rdy (a_rx_rdy), .rx_done (a_rx_done), .out_data (a_out_data),
        .flush (a_flush), .level (a_level), .empty (a_empty), .full (a_full),
        .almost_full (a_af), .almost_empty (a_ae)
    );

    param_hs_fifo #(.WIDTH(8), .DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
        .clk (clk), .rst_n (rst_n),
        .tx_rdy (b_tx_rdy), .tx_done (b_tx_done), .in_data (b_in_data),
        .rx_rdy (b_rx_rdy), .rx_done (b_rx_done), .out_data (b_out_data),
        .flush (b_flush), .level (b_level), .empty (b_empty), .full (b_full),
        .almost_full (b_af), .almost_empty (b_ae)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        int n;
        a_in_data = d;
        a_tx_rdy  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_tx_done && n < 20);
        check_eq("push_ack", a_tx_done, 1);
        a_tx_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_a(input logic [7:0] exp);
        int n;
        n = 0;
        while (!a_rx_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("pop_rdy", a_rx_rdy, 1);
        check_eq("pop_data", a_out_data, exp);
        a_rx_done = 1'b1;
        @(negedge clk);
        a_rx_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a_tx_rdy = 0; a_rx_done = 0; a_flush = 0; a_in_data = 0;
        b_tx_rdy = 0; b_rx_done = 0; b_flush = 0; b_in_data = 0;

        #12;
        check_eq("rst_tx_done", a_tx_done, 0);
        check_eq("rst_rx_rdy", a_rx_rdy, 0);
        check_eq("rst_out_data", a_out_data, 0);
        check_eq("rst_level", a_level, 0);
        check_eq("rst_empty", a_empty, 1);
        check_eq("rst_full", a_full, 0);
        check_eq("rst_ae", a_ae, 1);
        check_eq("rst_af", a_af, 0);
        check_eq("rst_b_ae", b_ae, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill to full, then a stalled sixth write released by one pop
        for (int i = 0; i < 5; i++) push_a(fill_v[i]);
        check_eq("fill_level", a_level, 5);
        check_eq("fill_full", a_full, 1);
        check_eq("fill_af", a_af, 1);
        check_eq("fill_empty", a_empty, 0);
        check_eq("fill_rx_rdy", a_rx_rdy, 1);
        check_eq("fill_head", a_out_data, 8'h11);
        a_in_data = 8'h66;
        a_tx_rdy  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("stall_tx_done", a_tx_done, 0);
        check_eq("stall_level", a_level, 5);
        a_rx_done = 1'b1;
        @(negedge clk);
        check_eq("stall_after_pop_tx_done", a_tx_done, 0);
        check_eq("stall_after_pop_level", a_level, 4);
        check_eq("stall_after_pop_full", a_full, 0);
        a_rx_done = 1'b0;
        @(negedge clk);
        check_eq("stall_write_tx_done", a_tx_done, 1);
        check_eq("stall_write_level", a_level, 5);
        a_tx_rdy = 1'b0;
        @(negedge clk);
        pop_a(8'h22); pop_a(8'h33); pop_a(8'h44); pop_a(8'h55); pop_a(8'h66);
        check_eq("drain_level", a_level, 0);
        check_eq("drain_empty", a_empty, 1);
        check_eq("drain_ae", a_ae, 1);

        // Seven words interleaved through a depth-5 queue, crossing the wrap point
        for (int i = 0; i < 3; i++) push_a(order_v[i]);
        for (int i = 3; i < 7; i++) begin
            push_a(order_v[i]);
            pop_a(order_v[i-3]);
        end
        for (int i = 4; i < 7; i++) pop_a(order_v[i]);
        check_eq("order_level", a_level, 0);

        // Push and pop on the same edge at level 3
        push_a(8'h31); push_a(8'h32); push_a(8'h33);
        check_eq("sim_pre_level", a_level, 3);
        check_eq("sim_pre_rx_rdy", a_rx_rdy, 1);
        check_eq("sim_pre_af", a_af, 0);
        check_eq("sim_pre_ae", a_ae, 0);
        a_in_data = 8'h34;
        a_tx_rdy  = 1'b1;
        a_rx_done = 1'b1;
        @(negedge clk);
        check_eq("sim_level", a_level, 3);
        check_eq("sim_af", a_af, 0);
        check_eq("sim_ae", a_ae, 0);
        check_eq("sim_tx_done", a_tx_done, 1);
        check_eq("sim_rx_rdy", a_rx_rdy, 0);
        a_tx_rdy  = 1'b0;
        a_rx_done = 1'b0;
        @(negedge clk);
        pop_a(8'h32); pop_a(8'h33); pop_a(8'h34);

        // Flush beats a pending write and a presented word
        for (int i = 0; i < 4; i++) push_a(8'h41 + 8'(i));
        check_eq("flush_pre_level", a_level, 4);
        check_eq("flush_pre_rx_rdy", a_rx_rdy, 1);
        a_in_data = 8'hEE;
        a_tx_rdy  = 1'b1;
        a_flush   = 1'b1;
        @(negedge clk);
        check_eq("flush_level", a_level, 0);
        check_eq("flush_empty", a_empty, 1);
        check_eq("flush_rx_rdy", a_rx_rdy, 0);
        check_eq("flush_tx_done", a_tx_done, 0);
        check_eq("flush_ae", a_ae, 1);
        check_eq("flush_full", a_full, 0);
        a_flush  = 1'b0;
        a_tx_rdy = 1'b0;
        @(negedge clk);
        check_eq("flush_post_level", a_level, 0);
        push_a(8'h5A);
        pop_a(8'h5A);

        // Asynchronous reset while a word is presented
        push_a(8'h61); push_a(8'h62);
        check_eq("areset_pre_rx_rdy", a_rx_rdy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("areset_rx_rdy", a_rx_rdy, 0);
        check_eq("areset_empty", a_empty, 1);
        check_eq("areset_level", a_level, 0);
        check_eq("areset_out_data", a_out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("areset_idle_rx_rdy", a_rx_rdy, 0);
        push_a(8'h70);
        pop_a(8'h70);

        // Threshold flags on DEPTH=6, AF_LEVEL=4, AE_LEVEL=1
        for (int i = 0; i < 4; i++) begin
            b_in_data = 8'(i + 1);
            b_tx_rdy  = 1'b1;
            @(negedge clk);
            check_eq("thr_tx_done", b_tx_done, 1);
            check_eq("thr_level", b_level, i + 1);
            check_eq("thr_af", b_af, b_af_exp[i]);
            check_eq("thr_ae", b_ae, b_ae_exp[i]);
            b_tx_rdy = 1'b0;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
